// File: rtl/nios2_mulx_sequencer.sv
// rtl/nios2_mulx_sequencer.sv - 32x32 multiply sequencer built on one 16x16 multiplier.
// Returns the low word (MUL) or the corrected high word (MULXUU/MULXSU/MULXSS).
module nios2_mulx_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CORR} state_t;

  state_t      state, state_nxt;
  logic [31:0] a, b;
  logic [1:0]  opq;
  logic [1:0]  k;
  logic [1:0]  pp_k;
  logic        pp_valid;
  logic [31:0] pp;
  logic [63:0] acc;
  logic [15:0] mul_x, mul_y;
  logic [31:0] prod;
  logic [63:0] pp_shifted;
  logic [31:0] hi_corr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (k == 2'd3) state_nxt = DRAIN;
      DRAIN:   state_nxt = CORR;
      CORR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // k[0] selects the a half, k[1] the b half, giving the 0,1,2,3 partial order.
  always_comb begin
    mul_x = k[0] ? a[31:16] : a[15:0];
    mul_y = k[1] ? b[31:16] : b[15:0];
    prod  = {16'd0, mul_x} * {16'd0, mul_y};
  end

  always_comb begin
    pp_shifted = 64'd0;
    case (pp_k)
      2'd0:    pp_shifted = {32'd0, pp};
      2'd1,
      2'd2:    pp_shifted = {16'd0, pp, 16'd0};
      default: pp_shifted = {pp, 32'd0};
    endcase
  end

  // Signed operands contribute -2^32 * other operand to the unsigned product.
  always_comb begin
    hi_corr = acc[63:32]
            - ((opq[1] && a[31]) ? b : 32'd0)
            - (((opq == 2'b11) && b[31]) ? a : 32'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a        <= 32'd0;
      b        <= 32'd0;
      opq      <= 2'd0;
      k        <= 2'd0;
      pp_k     <= 2'd0;
      pp_valid <= 1'b0;
      pp       <= 32'd0;
      acc      <= 64'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
    end else begin
      done     <= 1'b0;
      pp_valid <= (state == ISSUE);
      if (pp_valid) acc <= acc + pp_shifted;
      case (state)
        IDLE: begin
          if (start) begin
            a    <= src1;
            b    <= src2;
            opq  <= op;
            acc  <= 64'd0;
            k    <= 2'd0;
            busy <= 1'b1;
          end
        end
        ISSUE: begin
          pp   <= prod;
          pp_k <= k;
          k    <= k + 2'd1;
        end
        CORR: begin
          result <= (opq == 2'b00) ? acc[31:0] : hi_corr;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nios2_mulx_sequencer.md
# nios2_mulx_sequencer

Multi-cycle 32x32 multiply sequencer for the Nios II core's A-stage multiply path. It produces either the low word (MUL) or the high word (MULXUU/MULXSU/MULXSS) of a full 64-bit product. It uses one 16x16 unsigned multiplier with a registered product and iterates over the four partial products, applying the two's-complement high-word correction for signed variants. It sits beside the single-cycle-low-word multiply cell and serves the custom/extended multiply instructions that need the upper 32 bits.

## Interface
- No parameters. Widths are fixed: 32-bit operands, 16x16 multiplier, 64-bit accumulator.
- clk  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS
- src1  input  32  multiplicand, captured with start
- src2  input  32  multiplier, captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- result  output  32  selected product word; held until the next done

## Operation
- States: IDLE, ISSUE, DRAIN, CORR.
- IDLE with start=1:
  - latch src1, src2 and op into a, b and opq;
  - clear acc[63:0] and k;
  - go to ISSUE.
- IDLE with start=0: remain in IDLE.
- start while busy=1 is ignored; no queueing.
- ISSUE (k = 0..3): drive the multiplier operands and register the unsigned product pp.
  - k=0: a[15:0]*b[15:0]
  - k=1: a[31:16]*b[15:0]
  - k=2: a[15:0]*b[31:16]
  - k=3: a[31:16]*b[31:16]
- Accumulate on each edge after an issue: acc += pp << (0, 16, 16, 32 for k = 0..3). The sum is taken mod 2^64.
- After k=3 is issued, go to DRAIN for one cycle to accumulate the last product, then go to CORR.
- CORR computes the high-word correction, mod 2^32:
  - MULXSU: hi = acc[63:32] - (a[31] ? b : 0)
  - MULXSS: hi = acc[63:32] - (a[31] ? b : 0) - (b[31] ? a : 0)
  - MULXUU and MUL: no correction.
- result is loaded in CORR: acc[31:0] for MUL, the corrected hi word otherwise. The FSM then returns to IDLE with done=1.
- The low word is identical for all ops.

## Timing
- Reset values: busy=0, done=0, result=0, state=IDLE, acc=0, k=0.
- Reset asserted mid-operation aborts immediately. No done is produced, and result reads 0.
- Start accepted at edge T0; busy=1 from T0.
- Products are registered at T1..T4 and accumulated at T2..T5. CORR runs at T6.
- At T6: done=1 for exactly one cycle, result is valid, and busy=0.
- Fixed latency of 6 cycles for every op, including MUL.
- A new start sampled at T6 is not accepted (state is still CORR). The earliest next accept is T7, giving a throughput of one operation per 7 cycles.
- result is stable from T6 until the next done.
- Operand inputs may change after T0 without effect.

## Test plan
- Reset mid-operation: start at T0, reset_n low at T3, released at T5.
  - Required: no done; busy=0 and result=0 after reset.
  - A new start then completes normally with 6-cycle latency.
- src1=src2=0xFFFFFFFF:
  - MUL -> 0x00000001
  - MULXUU -> 0xFFFFFFFE
  - MULXSS -> 0x00000000
  - Each with done exactly 6 cycles after start and busy high for T0..T5.
- src1=src2=0x80000000:
  - MULXUU -> 0x40000000
  - MULXSS -> 0x40000000
  - MULXSU -> 0xC0000000
  - MUL -> 0x00000000
- src1=0xFFFFFFFF, src2=0x00000002:
  - MULXSU -> 0xFFFFFFFF
  - MULXUU -> 0x00000001
  - MUL -> 0xFFFFFFFE
- Busy handling: hold start=1 continuously with changing operands.
  - Required: accepts occur at T0, T7, T14.
  - Each result uses the operands sampled at its accept edge; intermediate starts are ignored.
  - result holds its value between done pulses.
- Random regression: 10k random src1/src2/op against a 64-bit signed/unsigned reference model.
  - Must be bit-exact, with done spacing of at least 7 cycles.
